// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator-style CPU control path.
// Contents: instruction/data/register-select widths, the 4-bit opcode
// enum, the sequencer state enum and the decoder output bundle.
package cpu_pkg;

  localparam int INSTR_W   = 9;
  localparam int DATA_W    = 8;
  localparam int REG_SEL_W = 3;
  localparam int OPC_W     = 4;

  // Opcodes 4'b1010..4'b1110 are deliberately left out: they decode as NOP.
  typedef enum logic [OPC_W-1:0] {
    OP_LOAD   = 4'b0000,
    OP_STORE  = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_BNE    = 4'b0011,
    OP_ADD    = 4'b0100,
    OP_MOV    = 4'b0101,
    OP_LSHIFT = 4'b0110,
    OP_RSHIFT = 4'b0111,
    OP_LOADI  = 4'b1000,
    OP_PARI   = 4'b1001,
    OP_HALT   = 4'b1111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_EXEC     = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_HALT     = 3'd4
  } state_e;

  // Decoder view of one instruction, independent of sequencer state.
  typedef struct packed {
    logic [OPC_W-1:0] alu_cmd;
    logic             reg_we;
    logic             mem_rd;
    logic             mem_we;
    logic             is_branch;
    logic             is_halt;
    logic             is_load;
  } dec_t;

endpackage

// File: rtl/ctrl_seq_if.sv
// Bus between the control sequencer and its neighbours (instruction ROM,
// branch LUT, register file, data memory, ALU).
// master = sequencer side, slave = datapath/memory side.
//   prog_addr_o  PC / ROM address         instr_i        ROM data
//   target_i     branch LUT data          branch_idx_o   LUT index
//   branch_bool_i ALU branch flag         alu_cmd_o      ALU command
//   reg_sel_o    register operand         imm_o          zero-extended immediate
//   reg_we_o / wb_sel_mem_o / mem_rd_o / mem_we_o   write/read strobes
interface ctrl_seq_if #(parameter int PC_W = 10);
  import cpu_pkg::*;

  logic [PC_W-1:0]      prog_addr_o;
  logic [INSTR_W-1:0]   instr_i;
  logic                 branch_bool_i;
  logic [PC_W-1:0]      target_i;
  logic [OPC_W-1:0]     alu_cmd_o;
  logic [REG_SEL_W-1:0] reg_sel_o;
  logic [DATA_W-1:0]    imm_o;
  logic [4:0]           branch_idx_o;
  logic                 reg_we_o;
  logic                 wb_sel_mem_o;
  logic                 mem_rd_o;
  logic                 mem_we_o;

  modport master (
    input  instr_i, branch_bool_i, target_i,
    output prog_addr_o, alu_cmd_o, reg_sel_o, imm_o, branch_idx_o,
           reg_we_o, wb_sel_mem_o, mem_rd_o, mem_we_o
  );

  modport slave (
    output instr_i, branch_bool_i, target_i,
    input  prog_addr_o, alu_cmd_o, reg_sel_o, imm_o, branch_idx_o,
           reg_we_o, wb_sel_mem_o, mem_rd_o, mem_we_o
  );

endinterface

// File: rtl/ctrl_seq_decode.sv
// Purely combinational instruction decoder (module ctrl_decode).
// Ports: i_ir  - latched instruction register
//        o_dec - ALU command and raw strobes/flags; the sequencer qualifies
//                them with its state.
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] i_ir,
  output dec_t               o_dec
);

  logic [OPC_W-1:0] w_opc;
  assign w_opc = i_ir[8:5];

  // Opcode to strobe/flag mapping; unlisted opcodes fall through as NOP.
  always_comb begin
    o_dec         = '0;
    o_dec.alu_cmd = w_opc;
    case (w_opc)
      OP_XOR, OP_ADD, OP_MOV, OP_LSHIFT,
      OP_RSHIFT, OP_LOADI, OP_PARI: o_dec.reg_we = 1'b1;
      OP_STORE: o_dec.mem_we = 1'b1;
      OP_LOAD: begin
        o_dec.mem_rd  = 1'b1;
        o_dec.is_load = 1'b1;
      end
      OP_BNE:  o_dec.is_branch = 1'b1;
      OP_HALT: o_dec.is_halt   = 1'b1;
      default: o_dec.reg_we    = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: fetches 9-bit instructions, holds PC/IR,
// and drives ALU command and register-file / data-memory strobes.
// Ports: clk, rst_n (async active-low), start (1-cycle run pulse),
//        bus (ctrl_seq_if.master: ROM, LUT, ALU, reg file, memory),
//        done_o (registered halt flag), instr_cnt_o (saturating retire count).
// Strobes are decoded from registered state and IR only, so an async reset
// removes them immediately and no write can survive an aborted instruction.
module ctrl_seq
  import cpu_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  ctrl_seq_if.master       bus,
  output logic             done_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  state_e             r_state;
  state_e             w_next;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  dec_t               w_dec;
  logic [PC_W-1:0]    w_pc_inc;
  logic [CNT_W-1:0]   w_cnt_sat;
  logic               w_in_exec;
  logic               w_in_mw;

  ctrl_decode u_decode (
    .i_ir  (r_ir),
    .o_dec (w_dec)
  );

  assign w_pc_inc  = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign w_cnt_sat = (&r_cnt) ? r_cnt : (r_cnt + {{(CNT_W-1){1'b0}}, 1'b1});
  assign w_in_exec = (r_state == ST_EXEC);
  assign w_in_mw   = (r_state == ST_MEM_WAIT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; start is only honoured in IDLE and HALT.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     w_next = start ? ST_FETCH : ST_IDLE;
      ST_FETCH:    w_next = ST_EXEC;
      ST_EXEC: begin
        if (w_dec.is_halt) begin
          w_next = ST_HALT;
        end else if (w_dec.is_load) begin
          w_next = ST_MEM_WAIT;
        end else begin
          w_next = ST_FETCH;
        end
      end
      ST_MEM_WAIT: w_next = ST_FETCH;
      ST_HALT:     w_next = start ? ST_FETCH : ST_HALT;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Output decode; strobes are mutually exclusive because EXEC strobes come
  // from a one-hot opcode decode and MEM_WAIT only raises reg_we.
  always_comb begin
    bus.prog_addr_o  = r_pc;
    bus.reg_sel_o    = r_ir[4:2];
    bus.imm_o        = {3'b000, r_ir[4:0]};
    bus.branch_idx_o = r_ir[4:0];
    bus.alu_cmd_o    = 4'b0000;
    bus.reg_we_o     = 1'b0;
    bus.wb_sel_mem_o = 1'b0;
    bus.mem_rd_o     = 1'b0;
    bus.mem_we_o     = 1'b0;
    if (w_in_exec) begin
      bus.alu_cmd_o = w_dec.alu_cmd;
      bus.reg_we_o  = w_dec.reg_we;
      bus.mem_rd_o  = w_dec.mem_rd;
      bus.mem_we_o  = w_dec.mem_we;
    end else if (w_in_mw) begin
      bus.reg_we_o     = 1'b1;
      bus.wb_sel_mem_o = 1'b1;
    end else begin
      bus.alu_cmd_o = 4'b0000;
    end
  end

  // PC, IR, retire counter and done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= '0;
      r_ir   <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            r_pc   <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
          end
        end
        ST_FETCH: r_ir <= bus.instr_i;
        ST_EXEC: begin
          // Loads retire in MEM_WAIT; everything else (halt included) here.
          if (!w_dec.is_load) begin
            r_cnt <= w_cnt_sat;
          end
          if (w_dec.is_branch) begin
            r_pc <= bus.branch_bool_i ? bus.target_i : w_pc_inc;
          end else if (w_dec.is_halt) begin
            r_done <= 1'b1;
          end else if (!w_dec.is_load) begin
            r_pc <= w_pc_inc;
          end
        end
        ST_MEM_WAIT: begin
          r_pc  <= w_pc_inc;
          r_cnt <= w_cnt_sat;
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign done_o      = r_done;
  assign instr_cnt_o = r_cnt;

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: stimulus pushes expected strobe cycles into
// a queue; a negedge monitor pops and compares whenever a strobe is high.
module tb_ctrl_seq;
  import cpu_pkg::*;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;
  localparam logic [8:0] I_HALT = 9'b1111_00000;

  typedef struct packed {
    logic       reg_we;
    logic       wb_sel;
    logic       mem_rd;
    logic       mem_we;
    logic [3:0] alu;
    logic [9:0] pc;
    logic [7:0] imm;
  } ev_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             done_o;
  logic [CNT_W-1:0] instr_cnt_o;
  logic             bb;
  logic [PC_W-1:0]  tgt;
  logic [8:0]       rom [0:1023];

  int  errors = 0;
  int  checks = 0;
  ev_t exp_q[$];
  ev_t m_exp;
  ev_t m_act;

  ctrl_seq_if #(.PC_W(PC_W)) bus ();

  ctrl_seq #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus),
    .done_o      (done_o),
    .instr_cnt_o (instr_cnt_o)
  );

  assign bus.instr_i       = rom[bus.prog_addr_o];
  assign bus.branch_bool_i = bb;
  assign bus.target_i      = tgt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic we, input logic wb, input logic rd, input logic mw,
                             input logic [3:0] alu, input logic [9:0] pc, input logic [7:0] imm);
    ev_t e;
    e = {we, wb, rd, mw, alu, pc, imm};
    return e;
  endfunction

  // Monitor: every strobe cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && (bus.reg_we_o || bus.mem_rd_o || bus.mem_we_o)) begin
      m_act = {bus.reg_we_o, bus.wb_sel_mem_o, bus.mem_rd_o, bus.mem_we_o,
               bus.alu_cmd_o, bus.prog_addr_o, bus.imm_o};
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {6'd0, m_act}, 32'd0);
      end else begin
        m_exp = exp_q.pop_front();
        chk("strobe_event", {6'd0, m_act}, {6'd0, m_exp});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst_n = 1'b0;
    for (int a = 0; a < 1024; a++) rom[a] = I_HALT;
    ticks(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Ends with the DUT in its first FETCH cycle.
  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic q_empty(input string nm);
    chk(nm, exp_q.size(), 32'd0);
  endtask

  initial begin
    bb  = 1'b0;
    tgt = '0;
    do_reset();

    // Reset state and loadi/halt run.
    chk("rst_pc", bus.prog_addr_o, 32'd0);
    chk("rst_done", done_o, 32'd0);
    chk("rst_cnt", instr_cnt_o, 32'd0);
    chk("rst_alu", bus.alu_cmd_o, 32'd0);
    chk("rst_strobes", {bus.reg_we_o, bus.mem_rd_o, bus.mem_we_o, bus.wb_sel_mem_o}, 32'd0);
    rom[0] = 9'b1000_00101;
    rom[1] = I_HALT;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h8, 10'd0, 8'h05));
    start_pulse();                                  // cycle 1
    tick();                                         // cycle 2 EXEC
    chk("loadi_imm", bus.imm_o, 32'h05);
    chk("loadi_we", bus.reg_we_o, 32'd1);
    ticks(2);                                       // cycle 4
    chk("done_early", done_o, 32'd0);
    tick();                                         // cycle 5
    chk("done_c5", done_o, 32'd1);
    chk("cnt_t1", instr_cnt_o, 32'd2);
    q_empty("q_t1");

    // bne taken, then restart from HALT with branch not taken.
    do_reset();
    rom[0]  = 9'b0011_00011;
    rom[1]  = I_HALT;
    rom[40] = I_HALT;
    tgt = 10'd40;
    bb  = 1'b1;
    start_pulse();
    tick();
    chk("bne_idx", bus.branch_idx_o, 32'd3);
    chk("bne_alu", bus.alu_cmd_o, 32'd3);
    tick();
    chk("bne_taken_pc", bus.prog_addr_o, 32'd40);
    ticks(2);
    chk("bne_done", done_o, 32'd1);
    bb = 1'b0;
    start_pulse();
    chk("restart_done_low", done_o, 32'd0);
    chk("restart_pc", bus.prog_addr_o, 32'd0);
    chk("restart_cnt", instr_cnt_o, 32'd0);
    ticks(2);
    chk("bne_not_taken_pc", bus.prog_addr_o, 32'd1);
    ticks(2);
    chk("cnt_t2", instr_cnt_o, 32'd2);
    q_empty("q_t2");

    // load: read strobe one cycle, memory write-back the next.
    do_reset();
    rom[0] = 9'b0000_01000;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 10'd0, 8'h08));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 10'd0, 8'h08));
    start_pulse();
    ticks(2);                                       // MEM_WAIT
    chk("load_pc_held", bus.prog_addr_o, 32'd0);
    tick();
    chk("load_pc_next", bus.prog_addr_o, 32'd1);
    ticks(2);
    chk("load_done", done_o, 32'd1);
    chk("cnt_t3", instr_cnt_o, 32'd2);
    q_empty("q_t3");

    // store: single write strobe, no register write.
    do_reset();
    rom[0] = 9'b0001_00100;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 10'd0, 8'h04));
    start_pulse();
    ticks(2);
    chk("store_pc_next", bus.prog_addr_o, 32'd1);
    ticks(2);
    chk("cnt_t4", instr_cnt_o, 32'd2);
    q_empty("q_t4");

    // PC wrap: branch to 0x3FF, add there, next fetch is address 0.
    do_reset();
    rom[0]       = 9'b0011_00000;
    rom[10'h3FF] = 9'b0100_00100;
    tgt = 10'h3FF;
    bb  = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h4, 10'h3FF, 8'h04));
    start_pulse();
    ticks(2);
    chk("wrap_pc_max", bus.prog_addr_o, 32'h3FF);
    ticks(2);
    chk("wrap_pc_zero", bus.prog_addr_o, 32'd0);
    chk("cnt_t5", instr_cnt_o, 32'd2);
    q_empty("q_t5");
    bb = 1'b0;

    // Reset during MEM_WAIT of a load at address 1.
    do_reset();
    rom[0] = 9'b1000_00101;
    rom[1] = 9'b0000_01000;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h8, 10'd0, 8'h05));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 10'd1, 8'h08));
    start_pulse();
    ticks(4);                                       // cycle 5 MEM_WAIT
    chk("mw_we_before_rst", {bus.reg_we_o, bus.wb_sel_mem_o}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_mw_we", {bus.reg_we_o, bus.wb_sel_mem_o, bus.mem_rd_o}, 32'd0);
    chk("rst_mw_pc", bus.prog_addr_o, 32'd0);
    chk("rst_mw_cnt", instr_cnt_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(3);
    chk("idle_hold_pc", bus.prog_addr_o, 32'd0);
    chk("idle_hold_done", done_o, 32'd0);
    q_empty("q_t6");

    // start during EXEC is ignored; NOP just advances.
    do_reset();
    rom[0] = 9'b1000_00111;
    rom[1] = 9'b0101_01100;
    rom[2] = 9'b1010_00000;
    rom[3] = I_HALT;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h8, 10'd0, 8'h07));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 10'd1, 8'h0C));
    start_pulse();
    tick();                                         // EXEC loadi
    start_pulse();
    chk("exec_start_pc", bus.prog_addr_o, 32'd1);
    chk("exec_start_cnt", instr_cnt_o, 32'd1);
    ticks(4);
    chk("nop_pc", bus.prog_addr_o, 32'd3);
    ticks(2);
    chk("t7_done", done_o, 32'd1);
    chk("cnt_t7", instr_cnt_o, 32'd4);
    q_empty("q_t7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Multi-cycle control sequencer for the 8-bit accumulator-style CPU.
- Fetches 9-bit instructions, holds PC, and decodes to the 4-bit ALU command plus register-file and data-memory strobes.
- Consumes branch_bool back from the ALU; sits between instruction ROM, branch LUT, reg file, data memory and the ALU.

Parameters:
- PC_W, 10, program counter / instruction ROM address width
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle pulse; begins run at PC 0 from IDLE or HALT
- instr_i  in  9  instruction ROM data (combinational read of prog_addr_o)
- branch_bool_i  in  1  ALU branch-taken flag, valid during EXEC
- target_i  in  PC_W  branch LUT data for branch_idx_o
- prog_addr_o  out  PC_W  current PC
- alu_cmd_o  out  4  ALU command, = IR[8:5] in EXEC, else 0
- reg_sel_o  out  3  register operand = IR[4:2]
- imm_o  out  8  zero-extended IR[4:0] (loadi)
- branch_idx_o  out  5  IR[4:0], LUT index for bne
- reg_we_o  out  1  register-file write enable
- wb_sel_mem_o  out  1  1 = write back memory data, 0 = ALU result
- mem_rd_o  out  1  data-memory read strobe
- mem_we_o  out  1  data-memory write strobe
- done_o  out  1  program halted
- instr_cnt_o  out  CNT_W  retired instructions, saturating

Behaviour:
- Opcodes: 0000 load, 0001 store, 0010 xor, 0011 bne, 0100 add, 0101 mov, 0110 lshift, 0111 rshift, 1000 loadi, 1001 pari, 1010-1110 NOP, 1111 halt.
- States: IDLE, FETCH, EXEC, MEM_WAIT, HALT.
- Reset (async, rst_n=0):
  - state=IDLE, PC=0, IR=0, instr_cnt_o=0.
  - All strobes, done_o and alu_cmd_o are 0.
  - Reset mid-instruction aborts with no pending write; strobes drop immediately.
- IDLE: start -> FETCH with PC=0, counter cleared; otherwise hold.
- FETCH:
  - prog_addr_o=PC; IR<=instr_i at clock edge.
  - -> EXEC.
- EXEC: outputs decoded from IR.
  - xor/add/mov/lshift/rshift/loadi/pari: reg_we_o=1, wb_sel_mem_o=0, PC<=PC+1, -> FETCH (2 cycles/instr).
  - store: mem_we_o=1 for this cycle only, PC<=PC+1, -> FETCH.
  - load: mem_rd_o=1, -> MEM_WAIT (PC held).
  - bne: no writes.
    - branch_bool_i=1 -> PC<=target_i.
    - branch_bool_i=0 -> PC<=PC+1.
    - -> FETCH.
  - NOP: PC<=PC+1, -> FETCH.
  - halt: -> HALT, PC unchanged.
  - Every instruction leaving EXEC (except load, counted in MEM_WAIT) increments instr_cnt_o; halt is counted.
- MEM_WAIT:
  - reg_we_o=1, wb_sel_mem_o=1 (1-cycle memory read latency).
  - PC<=PC+1, count++, -> FETCH (3 cycles/load).
- HALT:
  - done_o=1 (registered, asserted from first HALT cycle); all strobes 0.
  - start -> FETCH, PC=0, done_o cleared, counter cleared.
- start outside IDLE/HALT is ignored.
- PC increment wraps modulo 2^PC_W (max -> 0), no flag.
- instr_cnt_o saturates at all-ones.
- At most one of reg_we_o, mem_rd_o, mem_we_o is high in any cycle.
- Outside EXEC/MEM_WAIT, alu_cmd_o=0 and wb_sel_mem_o=0.

Decomposition:
- Shared package cpu_pkg:
  - opcode enum (4-bit, values above);
  - state enum;
  - INSTR_W=9, DATA_W=8, REG_SEL_W=3.
- One natural sub-module: ctrl_decode, purely combinational IR -> {alu_cmd, reg_we, mem_rd, mem_we, is_branch, is_halt, is_load}.
- ctrl_seq holds FSM, PC, IR and counter.

Test Plan:
- Reset then start; ROM[0]=loadi 5 (9'b1000_00101), ROM[1]=halt -> EXEC of addr 0: imm_o=8'h05, reg_we_o=1; done_o=1 at cycle 5 after start; instr_cnt_o=2.
- ROM[0]=bne idx 3, target_i=10'd40:
  - branch_bool_i=1 -> next prog_addr_o=40.
  - Rerun with branch_bool_i=0 -> next prog_addr_o=1.
- ROM[0]=load -> mem_rd_o=1 for exactly one cycle, then reg_we_o=1 with wb_sel_mem_o=1 next cycle; PC becomes 1 three cycles after FETCH entry.
- ROM[0]=store -> mem_we_o high exactly one cycle, reg_we_o stays 0.
- PC at 10'h3FF executing add -> next prog_addr_o=0.
- Assert rst_n=0 during MEM_WAIT -> reg_we_o drops same cycle, state IDLE, PC=0.
- start pulse while in EXEC has no effect.
- start in HALT restarts at PC 0 with done_o low next cycle.
